// File: rtl/tlul_tsens_poller.sv
// TL-UL host that runs one temperature-sensor conversion: enable, poll DONE, read DOUT, disable.
// Latency: each request takes one cycle from a_ready to the *_RSP state. Each DONE poll is followed by PollGap idle cycles.
// Backpressure: at most one request is outstanding. The request is held stable while a_ready=0. d_ready is always 1.
//
// Ports:
//   clk_i, rst_ni          clock and asynchronous active-low reset
//   tl_o / tl_i            TL-UL host request channel / device response channel
//   start_i, sensor_sel_i  start pulse and sensor index (sensor index is latched at start)
//   busy_o, done_o         sequence in progress / one-cycle completion pulse
//   err_o, result_o        status of the last sequence / last DOUT value read

package tlul_pkg;

   typedef enum logic [2:0] {
      PutFullData    = 3'h0,
      PutPartialData = 3'h1,
      Get            = 3'h4
   } tl_a_op_e;

   typedef enum logic [2:0] {
      AccessAck     = 3'h0,
      AccessAckData = 3'h1
   } tl_d_op_e;

   typedef struct packed {
      logic        a_valid;
      tl_a_op_e    a_opcode;
      logic [2:0]  a_param;
      logic [1:0]  a_size;
      logic [7:0]  a_source;
      logic [31:0] a_address;
      logic [3:0]  a_mask;
      logic [31:0] a_data;
      logic        d_ready;
   } tl_h2d_t;

   typedef struct packed {
      logic        d_valid;
      tl_d_op_e    d_opcode;
      logic [2:0]  d_param;
      logic [1:0]  d_size;
      logic [7:0]  d_source;
      logic        d_sink;
      logic [31:0] d_data;
      logic        d_error;
      logic        a_ready;
   } tl_d2h_t;

endpackage

module tlul_tsens_poller
   import tlul_pkg::*;
#(
   parameter logic [31:0] BaseAddr = 32'h0,
   parameter int unsigned SourceId = 0,
   parameter int unsigned MaxPolls = 255,
   parameter int unsigned PollGap  = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output tl_h2d_t     tl_o,
   input  tl_d2h_t     tl_i,
   input  logic        start_i,
   input  logic [1:0]  sensor_sel_i,
   output logic        busy_o,
   output logic        done_o,
   output logic        err_o,
   output logic [23:0] result_o
);

   // The poll counter is one bit wider than needed for MaxPolls, so the incremented value never wraps.
   localparam int unsigned PCW = $clog2(MaxPolls + 2);
   localparam int unsigned GCW = (PollGap > 1) ? $clog2(PollGap) : 1;

   localparam logic [31:0] OffEnable = 32'h0000_000C;
   localparam logic [31:0] OffDout   = 32'h0000_0010;
   localparam logic [31:0] OffDone   = 32'h0000_0014;

   typedef enum logic [3:0] {
      IDLE,
      EN_REQ,
      EN_RSP,
      POLL_REQ,
      POLL_RSP,
      GAP,
      DATA_REQ,
      DATA_RSP,
      DIS_REQ,
      DIS_RSP
   } state_e;

   typedef struct packed {
      logic        vld;
      tl_a_op_e    op;
      logic [31:0] addr;
      logic [31:0] data;
   } req_t;

   // Request fields for a *_REQ state. They are registered on entry, so they stay
   // constant for as long as the slave holds a_ready low.
   function automatic req_t mk_req(input state_e st, input logic [1:0] sel);
      req_t        r;
      logic [31:0] sel_off;
      sel_off = {27'd0, sel, 3'd0};
      r = '0;
      case (st)
         EN_REQ: begin
            r.vld  = 1'b1;
            r.op   = PutFullData;
            r.addr = BaseAddr + OffEnable;
            r.data = 32'd1;
         end
         DIS_REQ: begin
            r.vld  = 1'b1;
            r.op   = PutFullData;
            r.addr = BaseAddr + OffEnable;
            r.data = 32'd0;
         end
         POLL_REQ: begin
            r.vld  = 1'b1;
            r.op   = Get;
            r.addr = BaseAddr + OffDone + sel_off;
         end
         DATA_REQ: begin
            r.vld  = 1'b1;
            r.op   = Get;
            r.addr = BaseAddr + OffDout + sel_off;
         end
         default: r = '0;
      endcase
      return r;
   endfunction

   function automatic state_e rsp_of(input state_e st);
      case (st)
         EN_REQ:   return EN_RSP;
         POLL_REQ: return POLL_RSP;
         DATA_REQ: return DATA_RSP;
         default:  return DIS_RSP;
      endcase
   endfunction

   state_e           r_state;
   req_t             r_req;
   logic [1:0]       r_sel;
   logic [PCW-1:0]   r_poll_cnt;
   logic [GCW-1:0]   r_gap_cnt;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic [23:0]      r_result;

   logic [PCW-1:0]   w_poll_nxt;
   logic             w_poll_limit;
   logic             w_gap_last;
   logic             w_unused_d;

   assign w_poll_nxt   = r_poll_cnt + PCW'(1);
   assign w_poll_limit = (w_poll_nxt >= PCW'(MaxPolls));
   // GAP is never entered when PollGap is 0, so the wrapped constant in that case does not matter.
   assign w_gap_last   = (r_gap_cnt == GCW'(PollGap - 1));

   assign w_unused_d = ^{tl_i.d_opcode, tl_i.d_param, tl_i.d_size, tl_i.d_source,
                         tl_i.d_sink, tl_i.d_data[31:24]};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IDLE;
         r_req      <= '0;
         r_sel      <= '0;
         r_poll_cnt <= '0;
         r_gap_cnt  <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
         r_result   <= '0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_sel      <= sensor_sel_i;
                  r_err      <= 1'b0;
                  r_poll_cnt <= '0;
                  r_gap_cnt  <= '0;
                  r_busy     <= 1'b1;
                  r_state    <= EN_REQ;
                  r_req      <= mk_req(EN_REQ, sensor_sel_i);
               end
            end

            EN_REQ, POLL_REQ, DATA_REQ, DIS_REQ: begin
               if (tl_i.a_ready) begin
                  r_req.vld <= 1'b0;
                  r_state   <= rsp_of(r_state);
               end
            end

            EN_RSP: begin
               if (tl_i.d_valid) begin
                  if (tl_i.d_error) begin
                     r_err   <= 1'b1;
                     r_state <= DIS_REQ;
                     r_req   <= mk_req(DIS_REQ, r_sel);
                  end else begin
                     r_state <= POLL_REQ;
                     r_req   <= mk_req(POLL_REQ, r_sel);
                  end
               end
            end

            POLL_RSP: begin
               if (tl_i.d_valid) begin
                  if (tl_i.d_error) begin
                     r_err   <= 1'b1;
                     r_state <= DIS_REQ;
                     r_req   <= mk_req(DIS_REQ, r_sel);
                  end else if (tl_i.d_data[0]) begin
                     r_state <= DATA_REQ;
                     r_req   <= mk_req(DATA_REQ, r_sel);
                  end else begin
                     r_poll_cnt <= w_poll_nxt;
                     if (w_poll_limit) begin
                        r_err   <= 1'b1;
                        r_state <= DIS_REQ;
                        r_req   <= mk_req(DIS_REQ, r_sel);
                     end else if (PollGap == 0) begin
                        r_state <= POLL_REQ;
                        r_req   <= mk_req(POLL_REQ, r_sel);
                     end else begin
                        r_gap_cnt <= '0;
                        r_state   <= GAP;
                     end
                  end
               end
            end

            GAP: begin
               if (w_gap_last) begin
                  r_state <= POLL_REQ;
                  r_req   <= mk_req(POLL_REQ, r_sel);
               end else begin
                  r_gap_cnt <= r_gap_cnt + GCW'(1);
               end
            end

            DATA_RSP: begin
               if (tl_i.d_valid) begin
                  if (tl_i.d_error) begin
                     r_err <= 1'b1;
                  end else begin
                     r_result <= tl_i.d_data[23:0];
                  end
                  r_state <= DIS_REQ;
                  r_req   <= mk_req(DIS_REQ, r_sel);
               end
            end

            DIS_RSP: begin
               if (tl_i.d_valid) begin
                  if (tl_i.d_error) begin
                     r_err <= 1'b1;
                  end
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end

            default: begin
               r_state <= IDLE;
               r_req   <= '0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      tl_o           = '0;
      tl_o.a_valid   = r_req.vld;
      tl_o.a_opcode  = r_req.op;
      tl_o.a_param   = 3'd0;
      tl_o.a_size    = 2'd2;
      tl_o.a_source  = 8'(SourceId);
      tl_o.a_address = r_req.addr;
      tl_o.a_mask    = 4'hF;
      tl_o.a_data    = r_req.data;
      tl_o.d_ready   = 1'b1;
   end

   assign busy_o   = r_busy;
   assign done_o   = r_done;
   assign err_o    = r_err;
   assign result_o = r_result;

endmodule

// File: tb/tb_tlul_tsens_poller.sv
// Bench for tlul_tsens_poller: directed conversion vectors against a TL-UL device model.
// Latency: the model accepts a request at a negedge and responds on the following cycle.
// Backpressure: a_ready can be held low for a configurable number of cycles per request.
module tb_tlul_tsens_poller;
   import tlul_pkg::*;

   localparam logic [31:0] BASE = 32'hFFFF_FFF0;  // chosen so that register addresses wrap past 2^32
   localparam int          SRC  = 5;
   localparam int          MAXP = 3;
   localparam int          GAP  = 2;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   tl_h2d_t     tl_o;
   tl_d2h_t     tl_i;
   logic        start_i;
   logic [1:0]  sensor_sel_i;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic [23:0] result_o;

   always #5 clk_i = ~clk_i;

   tlul_tsens_poller #(
      .BaseAddr (BASE),
      .SourceId (SRC),
      .MaxPolls (MAXP),
      .PollGap  (GAP)
   ) dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .tl_o         (tl_o),
      .tl_i         (tl_i),
      .start_i      (start_i),
      .sensor_sel_i (sensor_sel_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .result_o     (result_o)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } rec_t;

   // errmode: 0 none, 1 error on enable, 2 error on first DONE read, 3 error on DOUT read, 4 error on disable
   typedef struct {
      logic [1:0]  sel;
      int          pbd;       // DONE reads returning 0 before the first 1
      logic [23:0] dout;
      int          errmode;
      int          stall;     // a_ready low cycles before each acceptance
      bit          restart;   // pulse start_i again while busy
      int          npoll;     // expected DONE Gets
      bit          dout_rd;   // expected DOUT Get
      bit          exp_err;
      logic [23:0] exp_res;
   } vec_t;

   int n_checks = 0;
   int n_errors = 0;

   rec_t        log_q[$];
   int          cyc = 0;
   int          done_cnt = 0;
   int          bad_fields = 0;
   int          unstable = 0;
   int          stall_seen = 0;
   int          stall_left = 0;
   int          stall_cfg = 0;
   int          poll_idx = 0;
   bit          rsp_pend = 0;
   bit          holding = 0;
   tl_h2d_t     hold_req;
   logic [31:0] rsp_data;
   bit          rsp_err;
   logic [1:0]  cfg_sel = 0;
   int          cfg_pbd = 0;
   logic [23:0] cfg_dout = 0;
   int          cfg_err = 0;

   function automatic logic [31:0] a_en();
      return BASE + 32'h0C;
   endfunction
   function automatic logic [31:0] a_dout(input logic [1:0] s);
      return BASE + 32'h10 + {27'd0, s, 3'd0};
   endfunction
   function automatic logic [31:0] a_done(input logic [1:0] s);
      return BASE + 32'h14 + {27'd0, s, 3'd0};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Device model: drives tl_i and observes tl_o on the negative edge.
   initial begin
      tl_i = '0;
      forever begin
         @(negedge clk_i);
         cyc++;
         if (tl_o.d_ready !== 1'b1) bad_fields++;
         if (done_o === 1'b1) done_cnt++;
         tl_i.d_valid = 1'b0;
         tl_i.d_error = 1'b0;
         tl_i.d_data  = '0;
         if (rst_ni !== 1'b1) begin
            rsp_pend     = 0;
            holding      = 0;
            tl_i.a_ready = 1'b0;
         end else if (rsp_pend) begin
            if (tl_o.a_valid !== 1'b0) bad_fields++;   // second request while one is outstanding
            tl_i.d_valid  = 1'b1;
            tl_i.d_data   = rsp_data;
            tl_i.d_error  = rsp_err;
            tl_i.d_source = 8'(SRC);
            tl_i.a_ready  = 1'b0;
            rsp_pend      = 0;
         end else if (tl_o.a_valid === 1'b1) begin
            if (tl_o.a_size !== 2'd2 || tl_o.a_mask !== 4'hF ||
                tl_o.a_source !== 8'(SRC) || tl_o.a_param !== 3'd0) bad_fields++;
            if (holding && tl_o !== hold_req) unstable++;
            if (stall_left > 0) begin
               tl_i.a_ready = 1'b0;
               if (!holding) begin
                  holding  = 1;
                  hold_req = tl_o;
               end
               stall_left--;
               stall_seen++;
            end else begin
               rec_t r;
               r.op   = tl_o.a_opcode;
               r.addr = tl_o.a_address;
               r.data = tl_o.a_data;
               r.cyc  = cyc;
               log_q.push_back(r);
               rsp_err  = 0;
               rsp_data = '0;
               if (r.op == 3'h4 && r.addr == a_done(cfg_sel)) begin
                  rsp_err  = (cfg_err == 2 && poll_idx == 0);
                  rsp_data = (poll_idx >= cfg_pbd) ? 32'h8000_0001 : 32'hFFFF_FFFE;
                  poll_idx++;
               end else if (r.op == 3'h4 && r.addr == a_dout(cfg_sel)) begin
                  rsp_data = {8'hEE, cfg_dout};
                  rsp_err  = (cfg_err == 3);
               end else if (r.op == 3'h0 && r.data == 32'd1) begin
                  rsp_err = (cfg_err == 1);
               end else begin
                  rsp_err = (cfg_err == 4);
               end
               rsp_pend     = 1;
               holding      = 0;
               tl_i.a_ready = 1'b1;
               stall_left   = stall_cfg;
            end
         end else begin
            tl_i.a_ready = 1'b0;
            holding      = 0;
         end
      end
   end

   task automatic arm(input vec_t v);
      cfg_sel    = v.sel;
      cfg_pbd    = v.pbd;
      cfg_dout   = v.dout;
      cfg_err    = v.errmode;
      stall_cfg  = v.stall;
      stall_left = v.stall;
      poll_idx   = 0;
      done_cnt   = 0;
      bad_fields = 0;
      unstable   = 0;
      stall_seen = 0;
      log_q.delete();
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      rec_t exp_q[$];
      rec_t e;
      bit   got;
      int   n;
      arm(v);
      @(posedge clk_i); #1;
      start_i      = 1'b1;
      sensor_sel_i = v.sel;
      @(posedge clk_i); #1;
      start_i      = 1'b0;
      sensor_sel_i = ~v.sel;     // the latched index must be the one used
      check($sformatf("v%0d busy after start", idx), busy_o, 1'b1);
      got = 0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk_i); #1;
         start_i = (v.restart && c == 3);
         if (done_o === 1'b1) begin
            got = 1;
            break;
         end
      end
      start_i = 1'b0;
      check($sformatf("v%0d done seen", idx), got, 1'b1);
      check($sformatf("v%0d err", idx), err_o, v.exp_err);
      check($sformatf("v%0d result", idx), result_o, v.exp_res);
      check($sformatf("v%0d busy at done", idx), busy_o, 1'b0);
      repeat (3) @(posedge clk_i);
      #1;
      check($sformatf("v%0d done pulses", idx), done_cnt, 1);
      check($sformatf("v%0d idle after", idx), busy_o, 1'b0);

      e.cyc = 0;
      e.op = 3'h0; e.addr = a_en(); e.data = 32'd1; exp_q.push_back(e);
      for (int p = 0; p < v.npoll; p++) begin
         e.op = 3'h4; e.addr = a_done(v.sel); e.data = 32'd0; exp_q.push_back(e);
      end
      if (v.dout_rd) begin
         e.op = 3'h4; e.addr = a_dout(v.sel); e.data = 32'd0; exp_q.push_back(e);
      end
      e.op = 3'h0; e.addr = a_en(); e.data = 32'd0; exp_q.push_back(e);

      check($sformatf("v%0d request count", idx), log_q.size(), exp_q.size());
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("v%0d req%0d addr", idx, i), log_q[i].addr, exp_q[i].addr);
         // Get carries no data, so only the opcode is compared for it.
         check($sformatf("v%0d req%0d op/data", idx, i),
               {log_q[i].op, (exp_q[i].op == 3'h4) ? 32'd0 : log_q[i].data},
               {exp_q[i].op, exp_q[i].data});
      end
      if (v.stall == 0) begin
         for (int i = 2; i <= v.npoll && i < log_q.size(); i++)
            check($sformatf("v%0d poll spacing %0d", idx, i),
                  log_q[i].cyc - log_q[i-1].cyc, GAP + 2);
      end else begin
         check($sformatf("v%0d stall cycles", idx), stall_seen, v.stall * exp_q.size());
      end
      check($sformatf("v%0d unstable request", idx), unstable, 0);
      check($sformatf("v%0d channel fields", idx), bad_fields, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t vecs[10];
      vec_t post;
      bit   got;
      vecs[0] = '{2'd2, 0, 24'h00ABCD, 0, 0, 1'b0, 1, 1'b1, 1'b0, 24'h00ABCD};
      vecs[1] = '{2'd0, 2, 24'h123456, 0, 0, 1'b0, 3, 1'b1, 1'b0, 24'h123456};
      vecs[2] = '{2'd1, 5, 24'hFFFFFF, 0, 0, 1'b0, 3, 1'b0, 1'b1, 24'h123456};
      vecs[3] = '{2'd3, 0, 24'h0F0F0F, 3, 0, 1'b0, 1, 1'b1, 1'b1, 24'h123456};
      vecs[4] = '{2'd3, 1, 24'hFEDCBA, 0, 0, 1'b1, 2, 1'b1, 1'b0, 24'hFEDCBA};
      vecs[5] = '{2'd1, 0, 24'h111111, 1, 0, 1'b0, 0, 1'b0, 1'b1, 24'hFEDCBA};
      vecs[6] = '{2'd0, 1, 24'h222222, 2, 0, 1'b0, 1, 1'b0, 1'b1, 24'hFEDCBA};
      vecs[7] = '{2'd2, 0, 24'hA5A5A5, 4, 0, 1'b0, 1, 1'b1, 1'b1, 24'hA5A5A5};
      vecs[8] = '{2'd2, 0, 24'h000001, 0, 0, 1'b0, 1, 1'b1, 1'b0, 24'h000001};
      vecs[9] = '{2'd1, 0, 24'h5A5A5A, 0, 5, 1'b0, 1, 1'b1, 1'b0, 24'h5A5A5A};
      post    = '{2'd0, 0, 24'h0BEEF0, 0, 0, 1'b0, 1, 1'b1, 1'b0, 24'h0BEEF0};

      rst_ni       = 1'b0;
      start_i      = 1'b0;
      sensor_sel_i = 2'd0;
      repeat (3) @(posedge clk_i);
      #1;
      check("reset a_valid", tl_o.a_valid, 1'b0);
      check("reset d_ready", tl_o.d_ready, 1'b1);
      check("reset busy", busy_o, 1'b0);
      check("reset done", done_o, 1'b0);
      check("reset err", err_o, 1'b0);
      check("reset result", result_o, 24'h0);
      rst_ni = 1'b1;

      for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

      // Reset while waiting for a DONE response: abort with no disable write.
      arm('{2'd1, 1000, 24'h0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 24'h0});
      @(posedge clk_i); #1;
      start_i      = 1'b1;
      sensor_sel_i = 2'd1;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      got = 0;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk_i); #1;
         if (log_q.size() >= 2) begin
            got = 1;
            break;
         end
      end
      check("rst reached poll", got, 1'b1);
      rst_ni = 1'b0;
      #1;
      check("rst a_valid", tl_o.a_valid, 1'b0);
      check("rst d_ready", tl_o.d_ready, 1'b1);
      check("rst busy", busy_o, 1'b0);
      check("rst done", done_o, 1'b0);
      check("rst err", err_o, 1'b0);
      check("rst result", result_o, 24'h0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      repeat (6) @(posedge clk_i);
      #1;
      check("rst no disable write", log_q.size(), 2);
      check("rst stays idle", busy_o, 1'b0);

      run_vec(post, 10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
